// File: rtl/pc_seq_if.sv
// Control and fetch-side signal bundle for pc_sequencer.
// The master is the control/fetch side; the slave is the sequencer itself.
interface pc_seq_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                enable;
  logic                fetch_ready;
  logic                jump;
  logic [PC_WIDTH-1:0] jump_target;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_offset;
  logic                halt;
  logic                resume;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus_step;
  logic                pc_valid;
  logic                redirect;
  logic                misaligned;

  modport master (
    output enable, fetch_ready, jump, jump_target, branch_taken,
           branch_offset, halt, resume,
    input  pc, pc_plus_step, pc_valid, redirect, misaligned
  );

  modport slave (
    input  enable, fetch_ready, jump, jump_target, branch_taken,
           branch_offset, halt, resume,
    output pc, pc_plus_step, pc_valid, redirect, misaligned
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: stepped advance, jump/branch redirects with
// alignment checking, fetch backpressure and a BOOT/RUN/HALT state machine.
module pc_sequencer #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter int unsigned         STEP         = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         ALIGN_BITS   = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] STEP_V = PC_WIDTH'(STEP);
  // ALIGN_BITS = 0 yields an empty mask, which accepts every target.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK =
    (PC_WIDTH'(1) << ALIGN_BITS) - PC_WIDTH'(1);

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  logic                redirect_q;
  logic                misaligned_q;

  logic                redir_req;
  logic [PC_WIDTH-1:0] target;
  logic                target_ok;

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    redir_req = 1'b0;
    target    = '0;
    target_ok = 1'b0;
    redir_req = bus.jump | bus.branch_taken;
    target    = bus.jump ? bus.jump_target : pc_q + bus.branch_offset;
    target_ok = (target & ALIGN_MASK) == '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc_q         <= RESET_VECTOR;
      redirect_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      case (state)
        BOOT: state <= RUN;

        RUN: begin
          if (bus.enable) begin
            if (redir_req) begin
              if (target_ok) begin
                pc_q       <= target;
                redirect_q <= 1'b1;
              end else begin
                misaligned_q <= 1'b1;
                state        <= HALT;
              end
            end else if (bus.fetch_ready) begin
              pc_q <= pc_q + STEP_V;
            end
            // Halt still lets this cycle's pc update land before freezing.
            if (bus.halt) state <= HALT;
          end
        end

        HALT: begin
          if (bus.enable && bus.resume) begin
            state        <= RUN;
            misaligned_q <= 1'b0;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus_step = pc_q + STEP_V;
  assign bus.pc_valid     = (state == RUN);
  assign bus.redirect     = redirect_q;
  assign bus.misaligned   = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a 32-bit and an 8-bit instance checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;

  pc_seq_if #(.PC_WIDTH(32)) bus32 ();
  pc_seq_if #(.PC_WIDTH(8))  bus8  ();

  pc_sequencer #(.PC_WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  pc_sequencer #(.PC_WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = booting, 1 = running, 2 = halted
  typedef struct {
    logic [31:0] pc;
    int          mode;
    bit          redirect;
    bit          misaligned;
  } model_t;

  typedef struct {
    bit          enable, fetch_ready, jump, branch_taken, halt, resume;
    logic [31:0] jump_target, branch_offset;
  } ctl_t;

  localparam model_t MODEL_RST = '{pc: 32'd0, mode: 0, redirect: 1'b0, misaligned: 1'b0};

  model_t m32 = MODEL_RST;
  model_t m8  = MODEL_RST;

  function automatic ctl_t mk_ctl(bit en, bit fr, bit j, bit b, bit h, bit r,
                                  logic [31:0] jt, logic [31:0] bo);
    ctl_t c;
    c.enable = en; c.fetch_ready = fr; c.jump = j; c.branch_taken = b;
    c.halt = h; c.resume = r; c.jump_target = jt; c.branch_offset = bo;
    return c;
  endfunction

  function automatic model_t model_next(model_t m, ctl_t c, int unsigned w);
    model_t      n = m;
    logic [31:0] mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    logic [31:0] tgt;
    n.redirect = 1'b0;
    if (m.mode == 0) begin
      n.mode = 1;
      return n;
    end
    if (!c.enable) return n;
    if (m.mode == 2) begin
      if (c.resume) begin
        n.mode = 1;
        n.misaligned = 1'b0;
      end
      return n;
    end
    if (c.jump || c.branch_taken) begin
      tgt = (c.jump ? c.jump_target : m.pc + c.branch_offset) & mask;
      if (tgt % 4 == 0) begin
        n.pc = tgt;
        n.redirect = 1'b1;
      end else begin
        n.misaligned = 1'b1;
        n.mode = 2;
      end
    end else if (c.fetch_ready) begin
      n.pc = (m.pc + 32'd4) & mask;
    end
    if (c.halt) n.mode = 2;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m32 = MODEL_RST;
      m8  = MODEL_RST;
    end else begin
      m32 = model_next(m32, mk_ctl(bus32.enable, bus32.fetch_ready, bus32.jump,
                                   bus32.branch_taken, bus32.halt, bus32.resume,
                                   bus32.jump_target, bus32.branch_offset), 32);
      m8  = model_next(m8, mk_ctl(bus8.enable, bus8.fetch_ready, bus8.jump,
                                  bus8.branch_taken, bus8.halt, bus8.resume,
                                  32'(bus8.jump_target), 32'(bus8.branch_offset)), 8);
    end
  end

  // Compare process: mid-cycle, away from the active edge.
  always @(negedge clk) begin
    check("m32.pc",           bus32.pc,           m32.pc);
    check("m32.pc_plus_step", bus32.pc_plus_step, m32.pc + 32'd4);
    check("m32.pc_valid",     32'(bus32.pc_valid),   32'(m32.mode == 1));
    check("m32.redirect",     32'(bus32.redirect),   32'(m32.redirect));
    check("m32.misaligned",   32'(bus32.misaligned), 32'(m32.misaligned));
    check("m8.pc",            32'(bus8.pc),          m8.pc);
    check("m8.pc_plus_step",  32'(bus8.pc_plus_step), (m8.pc + 32'd4) & 32'hFF);
    check("m8.pc_valid",      32'(bus8.pc_valid),    32'(m8.mode == 1));
    check("m8.redirect",      32'(bus8.redirect),    32'(m8.redirect));
    check("m8.misaligned",    32'(bus8.misaligned),  32'(m8.misaligned));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect32(input string name, input logic [31:0] pc, input bit valid,
                          input bit redir, input bit mis);
    check({name, ".pc"},         bus32.pc, pc);
    check({name, ".pc_valid"},   32'(bus32.pc_valid), 32'(valid));
    check({name, ".redirect"},   32'(bus32.redirect), 32'(redir));
    check({name, ".misaligned"}, 32'(bus32.misaligned), 32'(mis));
  endtask

  task automatic expect8(input string name, input logic [7:0] pc, input bit valid,
                         input bit redir, input bit mis);
    check({name, ".pc"},         32'(bus8.pc), 32'(pc));
    check({name, ".pc_valid"},   32'(bus8.pc_valid), 32'(valid));
    check({name, ".redirect"},   32'(bus8.redirect), 32'(redir));
    check({name, ".misaligned"}, 32'(bus8.misaligned), 32'(mis));
  endtask

  initial begin
    rst_n = 1'b0;
    bus32.enable = 1'b1; bus32.fetch_ready = 1'b1;
    bus32.jump = 1'b0;   bus32.jump_target = '0;
    bus32.branch_taken = 1'b0; bus32.branch_offset = '0;
    bus32.halt = 1'b0;   bus32.resume = 1'b0;
    bus8.enable = 1'b1;  bus8.fetch_ready = 1'b0;
    bus8.jump = 1'b0;    bus8.jump_target = '0;
    bus8.branch_taken = 1'b0; bus8.branch_offset = '0;
    bus8.halt = 1'b0;    bus8.resume = 1'b0;

    // 1. reset and boot
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    expect32("boot", 32'h0, 1'b0, 1'b0, 1'b0);
    check("boot.pc_plus_step", bus32.pc_plus_step, 32'h4);
    tick(); expect32("run0", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); expect32("run4", 32'h4, 1'b1, 1'b0, 1'b0);
    check("run4.pc_plus_step", bus32.pc_plus_step, 32'h8);
    tick(); expect32("run8", 32'h8, 1'b1, 1'b0, 1'b0);

    // 2. backpressure then stall
    bus32.fetch_ready = 1'b0;
    tick(); expect32("bp1", 32'h8, 1'b1, 1'b0, 1'b0);
    tick(); expect32("bp2", 32'h8, 1'b1, 1'b0, 1'b0);
    bus32.fetch_ready = 1'b1; bus32.enable = 1'b0;
    tick(); expect32("stall1", 32'h8, 1'b1, 1'b0, 1'b0);
    tick(); expect32("stall2", 32'h8, 1'b1, 1'b0, 1'b0);
    bus32.enable = 1'b1;
    tick(); expect32("reenable", 32'hC, 1'b1, 1'b0, 1'b0);
    tick(); expect32("at10", 32'h10, 1'b1, 1'b0, 1'b0);

    // 3. redirect priority and negative branch
    bus32.jump = 1'b1; bus32.jump_target = 32'h100;
    bus32.branch_taken = 1'b1; bus32.branch_offset = 32'h20;
    tick(); expect32("jump_wins", 32'h100, 1'b1, 1'b1, 1'b0);
    bus32.jump = 1'b0; bus32.branch_taken = 1'b0; bus32.fetch_ready = 1'b0;
    tick(); expect32("pulse_end", 32'h100, 1'b1, 1'b0, 1'b0);
    bus32.branch_taken = 1'b1; bus32.branch_offset = 32'hFFFF_FFF0;
    tick(); expect32("branch_back", 32'hF0, 1'b1, 1'b1, 1'b0);
    bus32.branch_taken = 1'b0; bus32.fetch_ready = 1'b1;
    tick(); expect32("after_branch", 32'hF4, 1'b1, 1'b0, 1'b0);

    // 4. misaligned jump and resume
    bus32.jump = 1'b1; bus32.jump_target = 32'h102;
    tick(); expect32("misaligned", 32'hF4, 1'b0, 1'b0, 1'b1);
    bus32.jump = 1'b0;
    tick(); expect32("halted", 32'hF4, 1'b0, 1'b0, 1'b1);
    bus32.resume = 1'b1;
    tick(); expect32("resumed", 32'hF4, 1'b1, 1'b0, 1'b0);
    bus32.resume = 1'b0;
    tick(); expect32("counting", 32'hF8, 1'b1, 1'b0, 1'b0);

    // 5. 8-bit wrap with same-cycle halt
    bus8.jump = 1'b1; bus8.jump_target = 8'hFC;
    tick(); expect8("w8_jump", 8'hFC, 1'b1, 1'b1, 1'b0);
    bus8.jump = 1'b0; bus8.fetch_ready = 1'b1; bus8.halt = 1'b1;
    tick(); expect8("w8_wrap_halt", 8'h00, 1'b0, 1'b0, 1'b0);
    check("w8.pc_plus_step", 32'(bus8.pc_plus_step), 32'h4);
    bus8.halt = 1'b0;
    tick(); expect8("w8_held", 8'h00, 1'b0, 1'b0, 1'b0);
    bus8.halt = 1'b1; bus8.resume = 1'b1;
    tick(); expect8("w8_resume_wins", 8'h00, 1'b1, 1'b0, 1'b0);
    bus8.halt = 1'b0; bus8.resume = 1'b0;
    tick(); expect8("w8_count", 8'h04, 1'b1, 1'b0, 1'b0);
    bus8.fetch_ready = 1'b0; bus8.jump = 1'b1; bus8.jump_target = 8'h06;
    tick(); expect8("w8_misaligned", 8'h04, 1'b0, 1'b0, 1'b1);
    bus8.jump = 1'b0;

    // 6. asynchronous reset during a redirect pulse
    bus32.jump = 1'b1; bus32.jump_target = 32'h40;
    tick(); expect32("pre_reset", 32'h40, 1'b1, 1'b1, 1'b0);
    bus32.jump = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expect32("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    check("async_rst.pc_plus_step", bus32.pc_plus_step, 32'h4);
    expect8("async_rst8", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    expect32("reboot", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); expect32("rerun0", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); expect32("rerun4", 32'h4, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
